// File: rtl/fast_square_frame_tagger_if.sv
// fast_square_frame_tagger_if: sample-in / word-pair-out bus between fast_square_rx, the tagger and rx_buffer.
interface fast_square_frame_tagger_if;
    logic        record;
    logic        freq_step;
    logic        in_strobe;
    logic [15:0] i_in;
    logic [15:0] q_in;
    logic        out_req;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        out_valid;

    modport master (
        output record, freq_step, in_strobe, i_in, q_in, out_req,
        input  i_out, q_out, out_valid
    );

    modport slave (
        input  record, freq_step, in_strobe, i_in, q_in, out_req,
        output i_out, q_out, out_valid
    );
endinterface

// File: rtl/fast_square_frame_tagger.sv
// fast_square_frame_tagger: buffers recorded I/Q pairs and tags each burst and frequency step with a sync/header pair.
module fast_square_frame_tagger #(
    parameter int          FIFO_LOG2 = 4,
    parameter logic [15:0] SYNC_WORD = 16'hA5A5,
    parameter logic [15:0] IDLE_WORD = 16'h8000,
    parameter int          STEP_W    = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_status,
    fast_square_frame_tagger_if.slave bus,
    output logic [STEP_W-1:0]     step_index,
    output logic                  overflow,
    output logic                  underflow,
    output logic [FIFO_LOG2:0]    fifo_level
);
    localparam int DEPTH = 1 << FIFO_LOG2;

    typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;

    state_t                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  skid_v_q, skid_v_d;
    logic [31:0]           skid_q, skid_d;
    logic [31:0]           mem_q [DEPTH];
    logic [FIFO_LOG2-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_LOG2:0]    cnt_q, cnt_d;
    logic [15:0]           i_out_q, i_out_d, q_out_q, q_out_d;
    logic                  valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                  push, pop, wr_en;
    logic [31:0]           push_data, sample;

    // Escaping the sync word in sample data keeps it unique to headers.
    always_comb sample = {(bus.i_in == SYNC_WORD) ? 16'hA5A4 : bus.i_in, bus.q_in};

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        skid_v_d  = 1'b0;
        skid_d    = skid_q;
        push      = 1'b0;
        push_data = sample;
        case (state_q)
            IDLE: begin
                if (bus.record) begin
                    state_d = HDR;
                    step_d  = '0;
                end
            end
            HDR: begin
                state_d   = STREAM;
                push      = 1'b1;
                push_data = {SYNC_WORD, 16'(step_q)};
                skid_v_d  = bus.in_strobe;
                skid_d    = sample;
            end
            default: begin
                push      = skid_v_q ? bus.record : bus.in_strobe;
                push_data = skid_v_q ? skid_q : sample;
                if (!bus.record) begin
                    state_d = IDLE;
                end else if (bus.freq_step) begin
                    state_d = HDR;
                    step_d  = step_q + 1'b1;
                end
            end
        endcase
    end

    // A full FIFO still accepts a push when the same cycle pops.
    always_comb begin
        pop     = bus.out_req && (cnt_q != '0);
        wr_en   = push && (!cnt_q[FIFO_LOG2] || pop);
        wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (FIFO_LOG2+1)'(wr_en) - (FIFO_LOG2+1)'(pop);
        i_out_d = pop ? mem_q[rd_q][31:16] : (bus.out_req ? IDLE_WORD : i_out_q);
        q_out_d = pop ? mem_q[rd_q][15:0]  : (bus.out_req ? IDLE_WORD : q_out_q);
        valid_d = bus.out_req;
        ovf_d   = (push && !wr_en) || (ovf_q && !clear_status);
        udf_d   = (bus.out_req && !pop && bus.record) || (udf_q && !clear_status);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            i_out_q  <= '0;
            q_out_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            i_out_q  <= i_out_d;
            q_out_q  <= q_out_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && wr_en) mem_q[wr_q] <= push_data;
    end

    assign bus.i_out     = i_out_q;
    assign bus.q_out     = q_out_q;
    assign bus.out_valid = valid_q;
    assign step_index    = step_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;
    assign fifo_level    = cnt_q;
endmodule

// File: tb/tb_fast_square_frame_tagger.sv
// tb_fast_square_frame_tagger: scoreboard bench; a queue models FIFO contents, drops and sticky flags.
module tb_fast_square_frame_tagger;
    localparam logic [15:0] IDLE = 16'h8000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_status = 1'b0;
    logic [7:0]  step_index;
    logic        overflow, underflow;
    logic [4:0]  fifo_level;

    fast_square_frame_tagger_if bus ();

    fast_square_frame_tagger dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_status (clear_status),
        .bus          (bus),
        .step_index   (step_index),
        .overflow     (overflow),
        .underflow    (underflow),
        .fifo_level   (fifo_level)
    );

    always #5 clock = ~clock;

    logic [31:0] exp_q [$];
    bit          ovf_m, udf_m;
    logic [7:0]  ms;
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One clock edge: pop before push, as the FIFO does.
    task automatic step(input bit push, input logic [31:0] pv);
        bit pop, rec, clr, su, so;
        logic [31:0] e;
        pop = bus.out_req;
        rec = bus.record;
        clr = clear_status;
        su  = 1'b0;
        so  = 1'b0;
        tick;
        if (pop) begin
            if (exp_q.size() == 0) begin
                e  = {IDLE, IDLE};
                su = rec;
            end else begin
                e = exp_q.pop_front();
            end
            chk("pair", {bus.i_out, bus.q_out}, e);
        end
        chk("valid", 32'(bus.out_valid), 32'(pop));
        if (push) begin
            if (exp_q.size() < 16) exp_q.push_back(pv);
            else so = 1'b1;
        end
        ovf_m = so | (ovf_m & ~clr);
        udf_m = su | (udf_m & ~clr);
        chk("level", 32'(fifo_level), exp_q.size());
        chk("ovf", 32'(overflow), 32'(ovf_m));
        chk("udf", 32'(underflow), 32'(udf_m));
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q, input logic [31:0] e);
        bus.in_strobe = 1'b1;
        bus.i_in      = i;
        bus.q_in      = q;
        step(1'b1, e);
        bus.in_strobe = 1'b0;
        step(1'b0, '0);
    endtask

    task automatic pops(input int n);
        bus.out_req = 1'b1;
        repeat (n) step(1'b0, '0);
        bus.out_req = 1'b0;
    endtask

    task automatic fstep(input logic [7:0] ns);
        bus.freq_step = 1'b1;
        step(1'b0, '0);
        bus.freq_step = 1'b0;
        step(1'b1, {16'hA5A5, 8'h00, ns});
    endtask

    task automatic clear;
        clear_status = 1'b1;
        step(1'b0, '0);
        clear_status = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_i"}, 32'(bus.i_out), 0);
        chk({tag, "_q"}, 32'(bus.q_out), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_step"}, 32'(step_index), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_udf"}, 32'(underflow), 0);
        chk({tag, "_level"}, 32'(fifo_level), 0);
    endtask

    initial begin
        bus.record    = 1'b0;
        bus.freq_step = 1'b0;
        bus.in_strobe = 1'b0;
        bus.i_in      = '0;
        bus.q_in      = '0;
        bus.out_req   = 1'b0;
        tick;
        tick;
        chk_reset("reset");
        reset_n = 1'b1;

        // Burst start: header then three samples, drained past empty.
        bus.record = 1'b1;
        step(1'b0, '0);
        step(1'b1, 32'hA5A5_0000);
        chk("step_start", 32'(step_index), 0);
        send(16'h0001, 16'h000A, 32'h0001_000A);
        step(1'b0, '0); step(1'b0, '0);
        send(16'h0002, 16'h0014, 32'h0002_0014);
        step(1'b0, '0); step(1'b0, '0);
        send(16'h0003, 16'h001E, 32'h0003_001E);
        step(1'b0, '0); step(1'b0, '0);
        pops(6);
        chk("udf_burst", 32'(underflow), 1);
        clear;

        // Frequency step with a sample landing in the header cycle (skid).
        bus.freq_step = 1'b1;
        step(1'b0, '0);
        bus.freq_step = 1'b0;
        bus.in_strobe = 1'b1;
        bus.i_in      = 16'h0055;
        bus.q_in      = 16'h0066;
        step(1'b1, 32'hA5A5_0001);
        bus.in_strobe = 1'b0;
        step(1'b1, 32'h0055_0066);
        chk("step_one", 32'(step_index), 1);
        pops(2);

        // Sync word in sample data is escaped.
        send(16'hA5A5, 16'h1234, 32'hA5A4_1234);
        pops(1);
        clear;

        // Fill: header plus 17 samples, the last two dropped.
        ms = 8'd2;
        fstep(ms);
        for (int k = 0; k < 17; k++) send(16'(16'h0100 + k), 16'(k), 32'(32'h0100_0000 + (k << 16) + k));
        chk("full_level", 32'(fifo_level), 16);
        chk("ovf_set", 32'(overflow), 1);
        clear;
        chk("ovf_clr", 32'(overflow), 0);

        // Full FIFO with simultaneous push and pop.
        bus.out_req   = 1'b1;
        bus.in_strobe = 1'b1;
        bus.i_in      = 16'h0777;
        bus.q_in      = 16'h0888;
        step(1'b1, 32'h0777_0888);
        bus.in_strobe = 1'b0;
        bus.out_req   = 1'b0;
        chk("full_pp_level", 32'(fifo_level), 16);
        chk("full_pp_ovf", 32'(overflow), 0);
        pops(16);
        chk("drained", 32'(fifo_level), 0);

        // Step index wrap 255 -> 0 while draining continuously.
        bus.out_req = 1'b1;
        for (int k = 0; k < 253; k++) begin
            ms = ms + 1'b1;
            fstep(ms);
        end
        chk("step_255", 32'(step_index), 255);
        ms = ms + 1'b1;
        fstep(ms);
        chk("step_wrap", 32'(step_index), 0);
        step(1'b0, '0);
        bus.out_req = 1'b0;
        clear;

        // Reset mid-burst.
        send(16'h0011, 16'h0022, 32'h0011_0022);
        bus.in_strobe = 1'b1;
        bus.i_in      = 16'h0033;
        bus.q_in      = 16'h0044;
        bus.out_req   = 1'b1;
        reset_n       = 1'b0;
        tick;
        chk_reset("midreset");
        bus.in_strobe = 1'b0;
        bus.out_req   = 1'b0;
        bus.record    = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        reset_n = 1'b1;
        step(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
